// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Purpose  : Machine-mode CSR register file for the five-stage core. Owns
//            MSTATUS, MIE, MTVEC (constant), MEPC and MIP; serves a
//            combinational read port to ID/EX, commits CSR instructions at
//            WB, and sequences interrupt trap entry, MRET and WFI sleep.
// Ports    : clk, rstn (async, active-low)
//            rd_addr / rd_data          : combinational CSR read port
//            wb_valid, wb_pc            : instruction at WB
//            wb_csr_op/addr/src         : CSR op at WB (00 none,01 RW,10 RS,11 RC)
//            wb_mret, wb_wfi            : WB instruction is MRET / WFI
//            ext_irq, tmr_irq           : level interrupt requests
//            trap_taken, trap_target    : trap redirect to MTVEC
//            mret_taken, mret_target    : return redirect to MEPC
//            stall_wfi                  : freeze pipeline while sleeping
// Options  : CSR_COUNTER_EN adds 64-bit mcycle/minstret counters
//            (0xB00/0xB80, 0xB02/0xB82, read-only aliases 0xC00.. 0xC82).
// Revision : 1.0 - initial release
// ============================================================================
module csr_file (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [1:0]  wb_csr_op,
  input  logic [11:0] wb_csr_addr,
  input  logic [31:0] wb_csr_src,
  input  logic        wb_mret,
  input  logic        wb_wfi,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  output logic        trap_taken,
  output logic [31:0] trap_target,
  output logic        mret_taken,
  output logic [31:0] mret_target,
  output logic        stall_wfi
);

  localparam logic [31:0] MTVEC_VAL    = 32'h0001_0000;
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
`ifdef CSR_COUNTER_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_SLEEP = 1'b1;

  // Architectural state: only the implemented field bits get flops.
  logic [0:0]  state;
  logic [0:0]  state_next;
  logic        mst_mie;
  logic        mst_mpie;
  logic [1:0]  mst_mpp;
  logic        mie_mtie;
  logic        mie_meie;
  logic [31:0] mepc;
  logic        mip_mtip;
  logic        mip_meip;
  logic [31:0] wfi_pc;
`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;
`endif

  logic [31:0] mstatus_word;
  logic [31:0] mie_word;
  logic [31:0] mip_word;
  logic        pend;
  logic        irq_go;
  logic        mret_go;
  logic        csr_we;
  logic [31:0] wb_old;
  logic [31:0] wb_new;

  assign mstatus_word = {19'd0, mst_mpp, 3'd0, mst_mpie, 3'd0, mst_mie, 3'd0};
  assign mie_word     = {20'd0, mie_meie, 3'd0, mie_mtie, 7'd0};
  assign mip_word     = {20'd0, mip_meip, 3'd0, mip_mtip, 7'd0};

  function automatic logic [31:0] csr_read(input logic [11:0] addr);
    logic [31:0] val;
    val = 32'd0;
    case (addr)
      ADDR_MSTATUS:   val = mstatus_word;
      ADDR_MIE:       val = mie_word;
      ADDR_MTVEC:     val = MTVEC_VAL;
      ADDR_MEPC:      val = mepc;
      ADDR_MIP:       val = mip_word;
`ifdef CSR_COUNTER_EN
      ADDR_MCYCLE,    ADDR_CYCLE:    val = mcycle[31:0];
      ADDR_MCYCLEH,   ADDR_CYCLEH:   val = mcycle[63:32];
      ADDR_MINSTRET,  ADDR_INSTRET:  val = minstret[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: val = minstret[63:32];
`endif
      default:        val = 32'd0;
    endcase
    return val;
  endfunction

  assign rd_data = csr_read(rd_addr);
  assign wb_old  = csr_read(wb_csr_addr);

  always_comb begin
    wb_new = wb_csr_src;
    case (wb_csr_op)
      OP_RW:   wb_new = wb_csr_src;
      OP_RS:   wb_new = wb_old | wb_csr_src;
      OP_RC:   wb_new = wb_old & ~wb_csr_src;
      default: wb_new = wb_old;
    endcase
  end

  // Priority trap > MRET > CSR write: a trapped WB instruction commits
  // nothing and is replayed after MRET.
  assign pend    = |(mip_word & mie_word);
  assign irq_go  = mst_mie & pend & (wb_valid | (state == ST_SLEEP));
  assign mret_go = wb_valid & wb_mret & ~irq_go;
  assign csr_we  = wb_valid & (wb_csr_op != 2'b00) & ~irq_go & ~mret_go;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      // A WFI that sees a pending interrupt retires as a NOP.
      ST_RUN:   if (wb_valid && wb_wfi && !pend) state_next = ST_SLEEP;
      // Wake on any enabled pending interrupt, whether or not MIE allows a trap.
      ST_SLEEP: if (pend) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_comb begin
    trap_taken = irq_go;
    mret_taken = mret_go;
    stall_wfi  = (state == ST_SLEEP) && !pend;
  end

  assign trap_target = MTVEC_VAL;
  assign mret_target = mepc;

  // ---------------------------------------------------------- CSR state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
      mst_mpp  <= 2'b00;
      mie_mtie <= 1'b0;
      mie_meie <= 1'b0;
      mepc     <= 32'd0;
      mip_mtip <= 1'b0;
      mip_meip <= 1'b0;
      wfi_pc   <= 32'd0;
    end else begin
      mip_mtip <= tmr_irq;
      mip_meip <= ext_irq;
      if (irq_go) begin
        // Waking from sleep resumes after the WFI rather than replaying it.
        mepc     <= (state == ST_SLEEP) ? (wfi_pc + 32'd4) : wb_pc;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
        mst_mpp  <= 2'b11;
      end else if (mret_go) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
        mst_mpp  <= 2'b11;
      end else if (csr_we) begin
        case (wb_csr_addr)
          ADDR_MSTATUS: begin
            mst_mie  <= wb_new[3];
            mst_mpie <= wb_new[7];
            mst_mpp  <= wb_new[12:11];
          end
          ADDR_MIE: begin
            mie_mtie <= wb_new[7];
            mie_meie <= wb_new[11];
          end
          ADDR_MEPC: mepc <= {wb_new[31:2], 2'b00};
          default: ;
        endcase
      end
      if ((state == ST_RUN) && (state_next == ST_SLEEP)) begin
        wfi_pc <= wb_pc;
      end
    end
  end

`ifdef CSR_COUNTER_EN
  // A software write replaces the addressed half and suppresses that
  // counter's increment for the cycle; the other half holds its value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcycle   <= 64'd0;
      minstret <= 64'd0;
    end else begin
      if (csr_we && (wb_csr_addr == ADDR_MCYCLE)) begin
        mcycle <= {mcycle[63:32], wb_new};
      end else if (csr_we && (wb_csr_addr == ADDR_MCYCLEH)) begin
        mcycle <= {wb_new, mcycle[31:0]};
      end else begin
        mcycle <= mcycle + 64'd1;
      end
      if (csr_we && (wb_csr_addr == ADDR_MINSTRET)) begin
        minstret <= {minstret[63:32], wb_new};
      end else if (csr_we && (wb_csr_addr == ADDR_MINSTRETH)) begin
        minstret <= {wb_new, minstret[31:0]};
      end else if (wb_valid && !irq_go) begin
        minstret <= minstret + 64'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Purpose  : Self-checking bench for csr_file. A word-level model of the
//            CSRs predicts every output each cycle; a vector table covers
//            field masking and read-modify-write ops; hand sequences cover
//            trap entry, MRET, WFI sleep/wake and reset while sleeping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [1:0]  wb_csr_op;
  logic [11:0] wb_csr_addr;
  logic [31:0] wb_csr_src;
  logic        wb_mret, wb_wfi, ext_irq, tmr_irq;
  logic        trap_taken, mret_taken, stall_wfi;
  logic [31:0] trap_target, mret_target;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csr_file dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_csr_op(wb_csr_op),
    .wb_csr_addr(wb_csr_addr), .wb_csr_src(wb_csr_src),
    .wb_mret(wb_mret), .wb_wfi(wb_wfi), .ext_irq(ext_irq), .tmr_irq(tmr_irq),
    .trap_taken(trap_taken), .trap_target(trap_target),
    .mret_taken(mret_taken), .mret_target(mret_target), .stall_wfi(stall_wfi)
  );

  // ---------------- reference model: whole CSR words with field masks
  logic [31:0] m_mstatus, m_mie, m_mepc, m_mip, m_wfi_pc;
  bit          m_sleep;
`ifdef CSR_COUNTER_EN
  logic [63:0] m_mcycle, m_minstret;
`endif

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return 32'h0001_0000;
      12'h341: return m_mepc;
      12'h344: return m_mip;
`ifdef CSR_COUNTER_EN
      12'hB00, 12'hC00: return m_mcycle[31:0];
      12'hB80, 12'hC80: return m_mcycle[63:32];
      12'hB02, 12'hC02: return m_minstret[31:0];
      12'hB82, 12'hC82: return m_minstret[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_pend();
    return (m_mip & m_mie) != 32'd0;
  endfunction

  function automatic bit m_irq();
    return m_mstatus[3] && m_pend() && (wb_valid || m_sleep);
  endfunction

  task automatic m_reset();
    m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mip = 0; m_wfi_pc = 0; m_sleep = 0;
`ifdef CSR_COUNTER_EN
    m_mcycle = 0; m_minstret = 0;
`endif
  endtask

  task automatic m_update();
    bit          pend, irq, mret, wr;
    logic [31:0] old, nv;
    pend = m_pend();
    irq  = m_irq();
    mret = wb_valid && wb_mret && !irq;
    wr   = wb_valid && (wb_csr_op != 2'b00) && !irq && !mret;
    old  = m_read(wb_csr_addr);
    nv   = (wb_csr_op == 2'b01) ? wb_csr_src :
           (wb_csr_op == 2'b10) ? (old | wb_csr_src) : (old & ~wb_csr_src);
`ifdef CSR_COUNTER_EN
    begin
      logic [63:0] nc, ni;
      nc = m_mcycle + 1;
      ni = m_minstret + ((wb_valid && !irq) ? 1 : 0);
      if (wr && wb_csr_addr == 12'hB00) nc = {m_mcycle[63:32], nv};
      if (wr && wb_csr_addr == 12'hB80) nc = {nv, m_mcycle[31:0]};
      if (wr && wb_csr_addr == 12'hB02) ni = {m_minstret[63:32], nv};
      if (wr && wb_csr_addr == 12'hB82) ni = {nv, m_minstret[31:0]};
      m_mcycle = nc; m_minstret = ni;
    end
`endif
    if (irq) begin
      m_mepc    = m_sleep ? m_wfi_pc + 4 : wb_pc;
      m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
    end else if (mret) begin
      m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (wr) begin
      if (wb_csr_addr == 12'h300) m_mstatus = nv & 32'h1888;
      if (wb_csr_addr == 12'h304) m_mie     = nv & 32'h0880;
      if (wb_csr_addr == 12'h341) m_mepc    = nv & ~32'h3;
    end
    if (!m_sleep && wb_valid && wb_wfi && !pend) begin
      m_sleep = 1; m_wfi_pc = wb_pc;
    end else if (m_sleep && pend) begin
      m_sleep = 0;
    end
    m_mip = (tmr_irq ? 32'h80 : 32'h0) | (ext_irq ? 32'h800 : 32'h0);
  endtask

  // ---------------- checking helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs applied; compares all outputs.
  task automatic settle();
    #1;
    chk("rd_data",     rd_data,     m_read(rd_addr));
    chk("trap_taken",  {31'd0, trap_taken}, {31'd0, m_irq()});
    chk("trap_target", trap_target, 32'h0001_0000);
    chk("mret_taken",  {31'd0, mret_taken}, {31'd0, wb_valid && wb_mret && !m_irq()});
    chk("mret_target", mret_target, m_mepc);
    chk("stall_wfi",   {31'd0, stall_wfi},  {31'd0, m_sleep && !m_pend()});
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid = 0; wb_pc = 0; wb_csr_op = 0; wb_csr_addr = 0; wb_csr_src = 0;
    wb_mret = 0; wb_wfi = 0;
  endtask

  task automatic wb_csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s);
    idle(); wb_valid = 1; wb_csr_op = op; wb_csr_addr = a; wb_csr_src = s;
    settle(); tick(); idle();
  endtask

  task automatic do_reset();
    idle(); ext_irq = 0; tmr_irq = 0; rd_addr = 0;
    rstn = 0;
    m_reset();
    settle();
    @(negedge clk); @(negedge clk);
    rstn = 1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[13];
  logic [11:0] alist[12];

  initial begin
    vt[0]  = '{2'b10, 12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
    vt[1]  = '{2'b11, 12'h300, 32'h0000_0008, 32'h0000_1880};
    vt[2]  = '{2'b01, 12'h300, 32'h0000_0000, 32'h0000_0000};
    vt[3]  = '{2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0000_0880};
    vt[4]  = '{2'b11, 12'h304, 32'h0000_0080, 32'h0000_0800};
    vt[5]  = '{2'b10, 12'h304, 32'h0000_0080, 32'h0000_0880};
    vt[6]  = '{2'b01, 12'h341, 32'h1234_5677, 32'h1234_5674};
    vt[7]  = '{2'b10, 12'h341, 32'h0000_0003, 32'h1234_5674};
    vt[8]  = '{2'b11, 12'h341, 32'hF000_0000, 32'h0234_5674};
    vt[9]  = '{2'b01, 12'h344, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[10] = '{2'b01, 12'h305, 32'h0000_0000, 32'h0001_0000};
    vt[11] = '{2'b01, 12'h123, 32'hFFFF_FFFF, 32'h0000_0000};
`ifdef CSR_COUNTER_EN
    vt[12] = '{2'b01, 12'hB00, 32'h0000_0005, 32'h0000_0005};
`else
    vt[12] = '{2'b01, 12'hB00, 32'h0000_0005, 32'h0000_0000};
`endif
    alist = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h344, 12'hB00,
              12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC02, 12'h123};

    // ---- reset state
    do_reset();
    foreach (alist[i]) begin
      rd_addr = alist[i]; #1;
      chk("reset_rd", rd_data, (alist[i] == 12'h305) ? 32'h0001_0000 : 32'h0);
    end
    rd_addr = 0;

    // ---- table: write, then read back the next cycle
    for (int i = 0; i < 13; i++) begin
      wb_csr(vt[i].op, vt[i].addr, vt[i].src);
      rd_addr = vt[i].addr;
      settle();
      chk("table_rd", rd_data, vt[i].exp);
      tick();
    end

    // ---- timer trap with a CSR write at WB, then MRET
    do_reset();
    wb_csr(2'b01, 12'h304, 32'h80);
    wb_csr(2'b10, 12'h300, 32'h8);
    tmr_irq = 1; settle(); tick();
    idle(); wb_valid = 1; wb_pc = 32'h124; wb_csr_op = 2'b01;
    wb_csr_addr = 12'h341; wb_csr_src = 32'hDEAD_0000;
    settle();
    chk("trap_taken_tmr", {31'd0, trap_taken}, 32'd1);
    chk("trap_target_tmr", trap_target, 32'h0001_0000);
    tick(); idle(); tmr_irq = 0;
    rd_addr = 12'h341; settle(); chk("mepc_after_trap", rd_data, 32'h124);
    tick();
    rd_addr = 12'h300; settle(); chk("mstatus_after_trap", rd_data, 32'h1880);
    tick();
    wb_valid = 1; wb_mret = 1; settle();
    chk("mret_taken", {31'd0, mret_taken}, 32'd1);
    chk("mret_target", mret_target, 32'h124);
    tick(); idle();
    rd_addr = 12'h300; settle(); chk("mstatus_after_mret", rd_data, 32'h1888);
    tick();

    // ---- WFI with MSTATUS.MIE=0: wake without trap
    do_reset();
    wb_csr(2'b01, 12'h304, 32'h800);
    wb_valid = 1; wb_wfi = 1; wb_pc = 32'h200; settle(); tick(); idle();
    for (int i = 0; i < 10; i++) begin
      settle(); chk("wfi_stall", {31'd0, stall_wfi}, 32'd1); tick();
    end
    ext_irq = 1; settle(); tick();
    rd_addr = 12'h341; settle();
    chk("wake_stall", {31'd0, stall_wfi}, 32'd0);
    chk("wake_no_trap", {31'd0, trap_taken}, 32'd0);
    chk("wake_mepc", rd_data, 32'd0);
    tick(); ext_irq = 0; settle(); tick(); settle(); tick();

    // ---- WFI with MSTATUS.MIE=1: trap in the wake cycle
    do_reset();
    wb_csr(2'b01, 12'h304, 32'h800);
    wb_csr(2'b10, 12'h300, 32'h8);
    wb_valid = 1; wb_wfi = 1; wb_pc = 32'h200; settle(); tick(); idle();
    for (int i = 0; i < 4; i++) begin settle(); tick(); end
    ext_irq = 1; settle(); tick();
    settle();
    chk("wake_trap", {31'd0, trap_taken}, 32'd1);
    chk("wake_trap_stall", {31'd0, stall_wfi}, 32'd0);
    tick(); ext_irq = 0;
    rd_addr = 12'h341; settle(); chk("wake_trap_mepc", rd_data, 32'h204);
    tick();

    // ---- reset while sleeping
    do_reset();
    wb_csr(2'b01, 12'h304, 32'h880);
    wb_csr(2'b01, 12'h341, 32'h44);
    wb_valid = 1; wb_wfi = 1; wb_pc = 32'h300; settle(); tick(); idle();
    settle(); chk("sleep_before_rst", {31'd0, stall_wfi}, 32'd1);
    rstn = 0; m_reset(); #1;
    chk("rst_sleep_stall", {31'd0, stall_wfi}, 32'd0);
    foreach (alist[i]) begin
      rd_addr = alist[i]; #1;
      chk("rst_sleep_rd", rd_data, (alist[i] == 12'h305) ? 32'h0001_0000 : 32'h0);
    end
    do_reset();

    // ---- counters: 100 cycles, 40 retired
    for (int i = 0; i < 100; i++) begin
      wb_valid = (i < 40); settle(); tick();
    end
    idle();
    rd_addr = 12'hB00; #1;
`ifdef CSR_COUNTER_EN
    chk("mcycle_100", rd_data, 32'd100);
    rd_addr = 12'hB02; #1; chk("minstret_40", rd_data, 32'd40);
`else
    chk("mcycle_absent", rd_data, 32'd0);
    rd_addr = 12'hB02; #1; chk("minstret_absent", rd_data, 32'd0);
`endif
    settle(); tick();

    // ---- randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      idle();
      wb_valid    = ($urandom_range(0, 9) < 7);
      wb_pc       = $urandom & 32'hFFFF_FFFC;
      wb_csr_op   = 2'($urandom_range(0, 3));
      wb_csr_addr = alist[$urandom_range(0, 11)];
      wb_csr_src  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      case ($urandom_range(0, 19))
        0: wb_mret = 1;
        1: wb_wfi  = 1;
        default: ;
      endcase
      if ($urandom_range(0, 29) == 0) tmr_irq = ~tmr_irq;
      if ($urandom_range(0, 29) == 0) ext_irq = ~ext_irq;
      rd_addr = alist[$urandom_range(0, 11)];
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file for the five-stage CPU: the owner and writer of MSTATUS, MIE, MTVEC, MEPC and MIP whose values the EX-stage CSR forwarding path reads. It gives a combinational read port to ID/EX and commits CSR instructions from WB. It also sequences interrupt trap entry, MRET return and WFI sleep. Trap and MRET redirects go to the IF-stage PC select.

## Interface
- No parameters. MTVEC is hard-wired to 32'h0001_0000.
- clk  in  1  core clock
- rstn  in  1  asynchronous reset, active-low
- rd_addr  in  12  CSR address from the ID/EX instruction
- rd_data  out  32  combinational read data, formatted as below; 0 for unimplemented addresses
- wb_valid  in  1  a valid instruction is at WB this cycle
- wb_pc  in  32  PC of the WB instruction
- wb_csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC; the pipeline suppresses RS/RC with rs1/uimm==0 by sending 00
- wb_csr_addr  in  12  CSR address at WB
- wb_csr_src  in  32  rs1 value or zero-extended uimm
- wb_mret, wb_wfi  in  1  WB instruction is MRET / WFI
- ext_irq, tmr_irq  in  1  level interrupt requests
- trap_taken  out  1  redirect to trap_target and flush IF..WB
- trap_target  out  32  always 32'h0001_0000
- mret_taken  out  1  redirect to mret_target and flush
- mret_target  out  32  current MEPC
- stall_wfi  out  1  freeze the whole pipeline

## Operation
- Field layout, with all other bits reading 0 and writes to them ignored:
  - MSTATUS 0x300: MIE[3], MPIE[7], MPP[12:11].
  - MIE 0x304: MTIE[7], MEIE[11].
  - MTVEC 0x305: read-only constant.
  - MEPC 0x341: full 32 bits, with bits [1:0] forced to 0 on write.
  - MIP 0x344: MTIP[7], MEIP[11]; read-only, software writes are ignored.
- MIP is registered from tmr_irq/ext_irq every cycle.
- CSR write at WB: old = current field-formatted value; new = src (RW), old|src (RS), old&~src (RC). The write is masked to the fields above.
- pend = |(MIP & MIE).
- irq_go = MSTATUS.MIE & pend & (wb_valid | state==SLEEP).
- Trap entry when irq_go is 1:
  - trap_taken=1.
  - MEPC ← wb_pc in RUN, or saved wfi_pc+4 in SLEEP.
  - MPIE ← MIE, MIE ← 0, MPP ← 2'b11.
  - The WB instruction is not committed: CSR write, MRET and WFI are all discarded, and it re-executes after MRET.
- MRET, when wb_valid & wb_mret & !irq_go:
  - mret_taken=1.
  - MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
- FSM states RUN and SLEEP:
  - RUN→SLEEP when wb_valid & wb_wfi & !pend; wfi_pc ← wb_pc.
  - With pend=1 the WFI retires as a NOP and the state stays RUN.
  - SLEEP: stall_wfi=1.
  - SLEEP→RUN when pend=1. If MSTATUS.MIE=1 the trap is taken in that same cycle; otherwise execution resumes with no trap.
- Priority: trap > MRET > CSR write. At most one of trap_taken and mret_taken is 1 in any cycle.

## Timing
- Reset values: MSTATUS=0, MIE=0, MEPC=0, MIP=0, state=RUN. All outputs are 0 except trap_target=32'h0001_0000 and mret_target=0.
- rd_data, trap_taken, mret_taken, mret_target and stall_wfi are combinational from registers and current inputs.
- All register updates occur at the next rising clk. A WB write is visible on rd_data the cycle after WB; same-cycle forwarding is the pipeline's job.
- An irq input rising at edge n sets MIP at edge n+1. trap_taken can assert in cycle n+1.
- stall_wfi deasserts combinationally in the wake cycle.
- rstn low at any time, including in SLEEP or mid-trap, returns everything to reset values immediately.

## Configuration
- CSR_COUNTER_EN defined:
  - 64-bit mcycle increments every cycle, including stall and SLEEP.
  - 64-bit minstret increments on wb_valid with no trap in that cycle.
  - Readable at 0xB00/0xB80 and 0xB02/0xB82, with user aliases at 0xC00/0xC80 and 0xC02/0xC82.
  - Writable via 0xB00/0xB80/0xB02/0xB82. A software write wins over the increment in the same cycle.
  - Both counters reset to 0.
- Not defined: these addresses read 0 and writes are ignored; no counter flops.

## Test plan
- Set MSTATUS: RS to 0x300 with src=32'hFFFF_FFFF → next-cycle rd_data@0x300 = 32'h0000_1888. Then RC with src=0x8 → 32'h0000_1880.
- Timer trap: MIE=0x80, MSTATUS.MIE=1, tmr_irq=1, wb_pc=0x0000_0124 with a pending RW to MEPC →
  - trap_taken=1, trap_target=0x0001_0000.
  - MEPC=0x124 (CSR write dropped).
  - MSTATUS=0x1880.
- MRET after the above → mret_taken=1, mret_target=0x124, MSTATUS=0x1888.
- WFI with MIE=0x800 and MSTATUS.MIE=0 at wb_pc=0x200 → stall_wfi=1 for 10 cycles. Raise ext_irq → stall_wfi drops, trap_taken=0, MEPC unchanged.
- Same WFI with MSTATUS.MIE=1 → in the wake cycle trap_taken=1 and MEPC=0x204. Drop rstn while in SLEEP → stall_wfi=0 and all CSRs 0.
- With CSR_COUNTER_EN: after reset plus 100 cycles with 40 retired instructions → 0xB00 reads 100 and 0xB02 reads 40 (±read-cycle offset). Without the macro both read 0.
